gmem_stream_adapter: RTL and testbench
======================================

# gmem_stream_adapter

Stream-to-burst adapter sitting directly upstream of the 4-lane global memory. It converts a serial 16-bit valid/ready word stream into one 4-lane write, and one 4-lane read into a serial word stream. It drives the memory's address, write enable and four write-data lanes, and consumes its four read-data lanes. Bursts are always exactly four words; exactly one memory access is made per burst.

## Interface
- `DW`, 16, word width (matches memory lanes)
- `AW`, 4, memory base-address width
- `LANES`, 4, words per burst (fixed; not to be overridden)

- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`
- `cmd_write`  in  1  1 = write burst, 0 = read burst
- `cmd_addr`  in  AW  burst base address
- `cmd_inc`  in  1  use internal pointer instead of `cmd_addr` (only with macro, see Configuration)
- `wr_valid`  in  1  write word offered
- `wr_ready`  out  1  write word accepted
- `wr_data`  in  DW  write word
- `rd_valid`  out  1  read word offered
- `rd_ready`  in  1  read word taken
- `rd_data`  out  DW  read word
- `rd_last`  out  1  marks 4th word of a read burst
- `gm_address`  out  AW  memory base address
- `gm_we`  out  1  memory write enable
- `gm_wd1`..`gm_wd4`  out  DW each  memory write lanes
- `gm_rd1`..`gm_rd4`  in  DW each  memory read lanes (combinational from `gm_address`)
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, FILL, COMMIT, FETCH, DRAIN. All handshake outputs decode from state.
- **IDLE:** `cmd_ready`=1. On `cmd_valid&cmd_ready`: latch base into `base_q`. Write goes to FILL with lane index 0; read goes to FETCH.
- **FILL:** `wr_ready`=1.
  - Each `wr_valid&wr_ready` stores `wr_data` into lane[idx] and increments idx.
  - Accepting with idx=3 goes to COMMIT.
  - `wr_valid` gaps stall indefinitely.
- **COMMIT:** `gm_we`=1 for exactly this cycle, with lanes 0..3 driven on `gm_wd1..4`. Next state is IDLE.
- **FETCH:** one cycle with `gm_address`=`base_q`. `gm_rd1..4` are captured into lanes 0..3 at the end of the cycle. Next state is DRAIN with idx 0.
- **DRAIN:** `rd_valid`=1, `rd_data`=lane[idx], `rd_last`=(idx==3).
  - `rd_valid` and `rd_data` stay stable until `rd_ready`.
  - The handshake with idx=3 goes to IDLE.
- `gm_address`=`base_q` (registered) in all states. `gm_we`=0 outside COMMIT.
- `gm_wd1..4` always reflect lane registers.
- `wr_valid` outside FILL and `cmd_valid` outside IDLE are ignored (their ready is 0).
- Address wrap is the memory's concern; the adapter passes the base unchanged.

## Timing
- Reset (`reset_n` low, any state, mid-burst included):
  - State is IDLE; `base_q`, lanes, idx and pointer are 0.
  - All outputs are 0, including `cmd_ready`, which is gated low while `reset_n`=0.
  - No write is issued for a partial FILL.
- Write burst, zero stalls: command accepted in cycle 0, words in cycles 1–4, `gm_we` in cycle 5, `cmd_ready` high in cycle 6.
- Read burst, `rd_ready` held high: command in cycle 0, FETCH in cycle 1, words in cycles 2–5 (`rd_last` in 5), `cmd_ready` high in cycle 6.
- Back-to-back commands cannot overlap. Minimum burst period is 6 cycles.

## Configuration
- `GMEM_ADAPT_AUTOINC_EN` defined:
  - Port `cmd_inc` exists, and there is an internal AW-bit pointer.
  - On acceptance with `cmd_inc`=1, base = pointer; otherwise base = `cmd_addr`.
  - On leaving COMMIT or the last DRAIN handshake, pointer = base+4, modulo 2^AW (12 → 0).
- Undefined: no `cmd_inc` port and no pointer; base is always `cmd_addr`.

## Structure
- Package `gmem_pkg` holds:
  - `DW`, `AW`, `LANES` constants
  - state enum `gmem_state_t`
  - `LAST_IDX`=`LANES`-1
- Sub-module `gmem_lane_buf` holds the four DW registers with two load modes:
  - indexed single-word load for FILL
  - parallel 4-word load for FETCH
  - It also provides an indexed read mux and exposes all four lanes.

## Test plan
- Write: cmd addr=2, words 0x1111, 0x2222, 0x3333, 0x4444 → one `gm_we` pulse, `gm_address`=2, `gm_wd1..4`=0x1111..0x4444, cycle 5.
- Read: model memory returns 0xA0..0xA3 at addr 5 → `rd_data` 0xA0, 0xA1, 0xA2, 0xA3, `rd_last` only on 0xA3.
- Backpressure: `rd_ready` toggling 1,0,0,1 and `wr_valid` gaps → data held stable, no duplicated or lost word, still a single `gm_we`.
- Reset asserted after 2 of 4 FILL words → `gm_we` never pulses; after release `cmd_ready`=1, and the next write carries only new data.
- `cmd_valid`/`wr_valid` asserted while busy → ignored, `cmd_ready`=0, lane contents unchanged.
- With `GMEM_ADAPT_AUTOINC_EN`: four `cmd_inc` writes → `gm_address` 0, 4, 8, 12, then 0 on the fifth.

Source files
------------

// File: rtl/gmem_pkg.sv
// gmem_pkg: shared constants, types and state encoding for the stream-to-burst adapter
package gmem_pkg;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int LANES = 4;
    localparam int LAST_IDX = LANES - 1;
    typedef logic [DW-1:0] word_t;
    typedef logic [AW-1:0] addr_t;
    typedef logic [$clog2(LANES)-1:0] idx_t;
    typedef logic [LANES-1:0][DW-1:0] lanes_t;
    typedef enum logic [2:0] {IDLE, FILL, COMMIT, FETCH, DRAIN} gmem_state_t;
endpackage

// File: rtl/gmem_stream_adapter_if.sv
// gmem_stream_adapter_if: command, word-stream and memory-side signals of the adapter
// cmd_inc exists only when GMEM_ADAPT_AUTOINC_EN is defined
interface gmem_stream_adapter_if;
    import gmem_pkg::*;
    logic cmd_valid;
    logic cmd_ready;
    logic cmd_write;
    addr_t cmd_addr;
`ifdef GMEM_ADAPT_AUTOINC_EN
    logic cmd_inc;
`endif
    logic wr_valid;
    logic wr_ready;
    word_t wr_data;
    logic rd_valid;
    logic rd_ready;
    word_t rd_data;
    logic rd_last;
    addr_t gm_address;
    logic gm_we;
    word_t gm_wd1;
    word_t gm_wd2;
    word_t gm_wd3;
    word_t gm_wd4;
    word_t gm_rd1;
    word_t gm_rd2;
    word_t gm_rd3;
    word_t gm_rd4;
    logic busy;
    modport slave (
        input cmd_valid, cmd_write, cmd_addr,
`ifdef GMEM_ADAPT_AUTOINC_EN
        input cmd_inc,
`endif
        input wr_valid, wr_data, rd_ready, gm_rd1, gm_rd2, gm_rd3, gm_rd4,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last,
        output gm_address, gm_we, gm_wd1, gm_wd2, gm_wd3, gm_wd4, busy
    );
    modport master (
        output cmd_valid, cmd_write, cmd_addr,
`ifdef GMEM_ADAPT_AUTOINC_EN
        output cmd_inc,
`endif
        output wr_valid, wr_data, rd_ready, gm_rd1, gm_rd2, gm_rd3, gm_rd4,
        input cmd_ready, wr_ready, rd_valid, rd_data, rd_last,
        input gm_address, gm_we, gm_wd1, gm_wd2, gm_wd3, gm_wd4, busy
    );
endinterface

// File: rtl/gmem_lane_buf.sv
// gmem_lane_buf: four word registers with indexed or parallel load and an indexed read mux
module gmem_lane_buf
    import gmem_pkg::*;
(
    input  logic   clock,
    input  logic   reset_n,
    input  logic   load_one,
    input  logic   load_all,
    input  idx_t   idx,
    input  word_t  wdata,
    input  lanes_t fill,
    output lanes_t lanes,
    output word_t  rdata
);
    lanes_t q;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) q <= '0;
        else if (load_all) q <= fill;
        else if (load_one) q[idx] <= wdata;
    end
    assign lanes = q;
    assign rdata = q[idx];
endmodule

// File: rtl/gmem_stream_adapter.sv
// gmem_stream_adapter: packs four stream words into one 4-lane memory write and unpacks one 4-lane read.
// Define GMEM_ADAPT_AUTOINC_EN to add cmd_inc and an auto-advancing base pointer.
module gmem_stream_adapter
    import gmem_pkg::*;
(
    input logic clock,
    input logic reset_n,
    gmem_stream_adapter_if.slave bus
);
    gmem_state_t state_q, state_d;
    idx_t idx_q, idx_d;
    addr_t base_q, base_d, sel_base;
    logic load_one, load_all, last;
    lanes_t lanes;
    word_t rdata;
    assign last = idx_q == idx_t'(LAST_IDX);
`ifdef GMEM_ADAPT_AUTOINC_EN
    addr_t ptr_q;
    logic done;
    // pointer advances once per finished burst, wrapping with the address width
    assign done = state_q == COMMIT || (state_q == DRAIN && bus.rd_ready && last);
    assign sel_base = bus.cmd_inc ? ptr_q : bus.cmd_addr;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else if (done) ptr_q <= base_q + AW'(LANES);
    end
`else
    assign sel_base = bus.cmd_addr;
`endif
    gmem_lane_buf u_buf (
        .clock    (clock),
        .reset_n  (reset_n),
        .load_one (load_one),
        .load_all (load_all),
        .idx      (idx_q),
        .wdata    (bus.wr_data),
        .fill     ({bus.gm_rd4, bus.gm_rd3, bus.gm_rd2, bus.gm_rd1}),
        .lanes    (lanes),
        .rdata    (rdata)
    );
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q <= '0;
            base_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            base_q <= base_d;
        end
    end
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        base_d = base_q;
        load_one = 1'b0;
        load_all = 1'b0;
        case (state_q)
            IDLE: if (bus.cmd_valid && bus.cmd_ready) begin
                base_d = sel_base;
                idx_d = '0;
                state_d = bus.cmd_write ? FILL : FETCH;
            end
            FILL: if (bus.wr_valid) begin
                load_one = 1'b1;
                idx_d = idx_q + 1'b1;
                state_d = last ? COMMIT : FILL;
            end
            COMMIT: state_d = IDLE;
            FETCH: begin
                load_all = 1'b1;
                idx_d = '0;
                state_d = DRAIN;
            end
            DRAIN: if (bus.rd_ready) begin
                idx_d = idx_q + 1'b1;
                state_d = last ? IDLE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end
    // cmd_ready is gated by reset so nothing is accepted while reset_n is low
    assign bus.cmd_ready = reset_n && state_q == IDLE;
    assign bus.wr_ready = state_q == FILL;
    assign bus.rd_valid = state_q == DRAIN;
    assign bus.rd_data = state_q == DRAIN ? rdata : '0;
    assign bus.rd_last = state_q == DRAIN && last;
    assign bus.busy = state_q != IDLE;
    assign bus.gm_address = base_q;
    assign bus.gm_we = state_q == COMMIT;
    assign bus.gm_wd1 = lanes[0];
    assign bus.gm_wd2 = lanes[1];
    assign bus.gm_wd3 = lanes[2];
    assign bus.gm_wd4 = lanes[3];
endmodule

// File: tb/tb_gmem_stream_adapter.sv
// tb_gmem_stream_adapter: directed and randomized bursts checked against a burst-level memory model
module tb_gmem_stream_adapter;
    import gmem_pkg::*;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;
    gmem_stream_adapter_if bus();
    gmem_stream_adapter dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    lanes_t mem [16];
    lanes_t ref_mem [16];
    int we_count = 0;
    logic poke = 1'b0;
    addr_t poke_addr = '0;
    lanes_t poke_data = '0;
    int errors = 0;
    int checks = 0;
    assign bus.gm_rd1 = mem[bus.gm_address][0];
    assign bus.gm_rd2 = mem[bus.gm_address][1];
    assign bus.gm_rd3 = mem[bus.gm_address][2];
    assign bus.gm_rd4 = mem[bus.gm_address][3];
    always @(posedge clock) begin
        if (bus.gm_we) begin
            mem[bus.gm_address] <= {bus.gm_wd4, bus.gm_wd3, bus.gm_wd2, bus.gm_wd1};
            we_count <= we_count + 1;
        end else if (poke) mem[poke_addr] <= poke_data;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    function automatic lanes_t wd();
        return {bus.gm_wd4, bus.gm_wd3, bus.gm_wd2, bus.gm_wd1};
    endfunction
    task automatic do_write(input addr_t cmd_a, input addr_t exp_a, input lanes_t w, input bit gaps);
        int wc;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr = cmd_a;
        check("wr_cmd_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = gaps;
        wc = we_count;
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.wr_valid = 1'b0;
                    check("fill_wr_ready", bus.wr_ready, 1);
                    check("fill_cmd_ignored", bus.cmd_ready, 0);
                    tick();
                end
            end
            bus.wr_valid = 1'b1;
            bus.wr_data = w[i];
            check("fill_wr_ready", bus.wr_ready, 1);
            tick();
        end
        bus.wr_valid = 1'b0;
        bus.cmd_valid = 1'b0;
        check("commit_we", bus.gm_we, 1);
        check("commit_addr", bus.gm_address, exp_a);
        check("commit_lanes", wd(), w);
        tick();
        check("we_once", we_count - wc, 1);
        check("we_low", bus.gm_we, 0);
        check("write_done_ready", bus.cmd_ready, 1);
        ref_mem[exp_a] = w;
        check("mem_contents", mem[exp_a], ref_mem[exp_a]);
    endtask
    task automatic do_read(input addr_t a, input logic [15:0] pat_in, input bit junk);
        lanes_t e;
        logic [15:0] pat;
        bit took;
        int wc;
        e = ref_mem[a];
        wc = we_count;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr = a;
        check("rd_cmd_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = junk;
        check("fetch_addr", bus.gm_address, a);
        check("fetch_no_valid", bus.rd_valid, 0);
        check("fetch_busy", bus.busy, 1);
        tick();
        pat = pat_in;
        for (int i = 0; i < 4; i++) begin
            took = 1'b0;
            while (!took) begin
                bus.rd_ready = pat[0];
                bus.wr_valid = junk;
                bus.wr_data = 16'($urandom);
                check("drain_valid", bus.rd_valid, 1);
                check("drain_data", bus.rd_data, e[i]);
                check("drain_last", bus.rd_last, i == 3);
                if (junk) check("drain_wr_ignored", bus.wr_ready, 0);
                took = pat[0];
                pat = {1'b1, pat[15:1]};
                tick();
            end
        end
        bus.rd_ready = 1'b0;
        bus.wr_valid = 1'b0;
        bus.cmd_valid = 1'b0;
        check("read_done_ready", bus.cmd_ready, 1);
        check("read_done_valid", bus.rd_valid, 0);
        check("read_no_we", we_count - wc, 0);
    endtask
    initial begin
        lanes_t w;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr = '0;
`ifdef GMEM_ADAPT_AUTOINC_EN
        bus.cmd_inc = 1'b0;
`endif
        bus.wr_valid = 1'b0;
        bus.wr_data = '0;
        bus.rd_ready = 1'b0;
        tick();
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_we", bus.gm_we, 0);
        check("rst_addr", bus.gm_address, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_wr_ready", bus.wr_ready, 0);
        for (int i = 0; i < 16; i++) begin
            poke = 1'b1;
            poke_addr = addr_t'(i);
            poke_data = i == 5 ? 64'h00A3_00A2_00A1_00A0 : {$urandom, $urandom};
            ref_mem[i] = poke_data;
            tick();
        end
        poke = 1'b0;
        reset_n = 1'b1;
        tick();
        check("idle_cmd_ready", bus.cmd_ready, 1);
        do_write(4'd2, 4'd2, 64'h4444_3333_2222_1111, 1'b0);
        bus.wr_valid = 1'b1;
        bus.wr_data = 16'hDEAD;
        check("idle_wr_ignored", bus.wr_ready, 0);
        tick();
        bus.wr_valid = 1'b0;
        check("idle_lanes_kept", wd(), 64'h4444_3333_2222_1111);
        do_read(4'd5, 16'hFFFF, 1'b0);
        do_read(4'd2, 16'hFFF9, 1'b1);
        do_write(4'd9, 4'd9, 64'h0BB4_0BB3_0BB2_0BB1, 1'b1);
        do_read(4'd9, 16'hFFF9, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr = 4'd3;
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data = 16'h5500 + 16'(i);
            tick();
        end
        bus.wr_valid = 1'b0;
        begin
            int wc;
            wc = we_count;
            #2 reset_n = 1'b0;
            #1;
            check("midrst_cmd_ready", bus.cmd_ready, 0);
            check("midrst_busy", bus.busy, 0);
            check("midrst_we", bus.gm_we, 0);
            check("midrst_addr", bus.gm_address, 0);
            check("midrst_lanes", wd(), 0);
            tick();
            tick();
            reset_n = 1'b1;
            tick();
            check("postrst_ready", bus.cmd_ready, 1);
            check("postrst_no_we", we_count - wc, 0);
        end
        do_write(4'd3, 4'd3, 64'h6664_6663_6662_6661, 1'b0);
`ifdef GMEM_ADAPT_AUTOINC_EN
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        bus.cmd_inc = 1'b1;
        for (int k = 0; k < 5; k++) do_write(addr_t'($urandom), addr_t'(4 * k), {$urandom, $urandom}, 1'b0);
        bus.cmd_inc = 1'b0;
`endif
        for (int it = 0; it < 24; it++) begin
            addr_t a;
            a = addr_t'($urandom_range(0, 15));
            w = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) do_write(a, a, w, 1'b1);
            else do_read(a, 16'($urandom), 1'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
